text_overlay: RTL and testbench

- Parametrised HUD text renderer for the Tetris display. Shows NUM_FIELDS unsigned counters (score, level, rows cleared, ...) as decimal strings on a fixed character grid.
- Binary-to-BCD conversion is sequential, runs once per frame, and is double-buffered so digits never tear mid-frame.
- The pixel path is a fixed 2-cycle pipeline into the synchronous 8x16 font ROM. Its output feeds the color mapper alongside the board and piece layers.

---
 rtl/text_overlay_pkg.sv | 19 +
 rtl/font_rom.sv | 32 +++
 rtl/text_overlay_bin2bcd.sv | 67 ++++++
 rtl/text_overlay.sv | 192 +++++++++++++++++++
 tb/tb_text_overlay.sv | 268 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/text_overlay_pkg.sv
// Shared types and constants for the HUD text overlay and its BCD converter.
package text_overlay_pkg;

    localparam int CHAR_W = 8;
    localparam int CHAR_H = 16;

    localparam logic [7:0] ASCII_ZERO  = 8'h30;
    localparam logic [7:0] ASCII_SPACE = 8'h20;

    typedef enum logic [2:0] {IDLE, LOAD, SHIFT, STORE, COMMIT} conv_state_t;

    typedef logic [3:0] bcd_digit_t;

    // Double-dabble correction applied to each digit before every shift.
    function automatic bcd_digit_t bcd_adjust(input bcd_digit_t d);
        return (d >= 4'd5) ? bcd_digit_t'(d + 4'd3) : d;
    endfunction

endpackage

// File: rtl/font_rom.sv
// Synchronous 8x16 glyph ROM: addr = {code[6:0], row}, data registered, MSB is the leftmost pixel.
module font_rom (
    input  logic        Clk,
    input  logic [10:0] addr,
    output logic [7:0]  data
);

    logic [127:0] w_glyph;

    // Only the glyphs the HUD can show are populated; space and all other codes are blank.
    always_comb begin
        w_glyph = '0;
        case (addr[10:4])
            7'h30: w_glyph = 128'h00007CC6C6CEDEF6E6C6C67C00000000;
            7'h31: w_glyph = 128'h00001838781818181818187E00000000;
            7'h32: w_glyph = 128'h00007CC6060C183060C0C6FE00000000;
            7'h33: w_glyph = 128'h00007CC606063C060606C67C00000000;
            7'h34: w_glyph = 128'h00000C1C3C6CCCFE0C0C0C1E00000000;
            7'h35: w_glyph = 128'h0000FEC0C0C0FC060606C67C00000000;
            7'h36: w_glyph = 128'h00003860C0C0FCC6C6C6C67C00000000;
            7'h37: w_glyph = 128'h0000FEC606060C183030303000000000;
            7'h38: w_glyph = 128'h00007CC6C6C67CC6C6C6C67C00000000;
            7'h39: w_glyph = 128'h00007CC6C6C67E0606060C7800000000;
            default: w_glyph = '0;
        endcase
    end

    always_ff @(posedge Clk) begin
        data <= w_glyph[{~addr[3:0], 3'b111} -: 8];
    end

endmodule

// File: rtl/text_overlay_bin2bcd.sv
// Sequential double-dabble converter: one bit per cycle, sticky overflow when a
// carry leaves the top digit (value does not fit in DIGITS decimal digits).
module bin2bcd_seq
    import text_overlay_pkg::*;
#(
    parameter int VAL_W  = 20,
    parameter int DIGITS = 6
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  start,
    input  logic [VAL_W-1:0]      bin,
    output logic                  done,
    output logic [DIGITS*4-1:0]   bcd,
    output logic                  overflow
);

    localparam int CNT_W = $clog2(VAL_W + 1);

    logic [VAL_W-1:0]    r_bin;
    logic [DIGITS*4-1:0] r_bcd;
    logic [DIGITS*4-1:0] w_adj;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_ovf;
    logic                r_active;
    logic                r_done;

    always_comb begin
        w_adj = '0;
        for (int k = 0; k < DIGITS; k++) begin
            w_adj[k*4 +: 4] = bcd_adjust(r_bcd[k*4 +: 4]);
        end
    end

    // done stays high until the next start so the caller can sample it at leisure.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_bin    <= '0;
            r_bcd    <= '0;
            r_cnt    <= '0;
            r_ovf    <= 1'b0;
            r_active <= 1'b0;
            r_done   <= 1'b0;
        end else if (start) begin
            r_bin    <= bin;
            r_bcd    <= '0;
            r_cnt    <= CNT_W'(VAL_W);
            r_ovf    <= 1'b0;
            r_active <= 1'b1;
            r_done   <= 1'b0;
        end else if (r_active) begin
            r_bcd <= {w_adj[DIGITS*4-2:0], r_bin[VAL_W-1]};
            r_ovf <= r_ovf | w_adj[DIGITS*4-1];
            r_bin <= r_bin << 1;
            r_cnt <= r_cnt - 1'b1;
            if (r_cnt == CNT_W'(1)) begin
                r_active <= 1'b0;
                r_done   <= 1'b1;
            end
        end
    end

    assign done     = r_done;
    assign bcd      = r_bcd;
    assign overflow = r_ovf;

endmodule

// File: rtl/text_overlay.sv
// HUD text renderer: per-frame double-buffered BCD conversion of the counters and a
// fixed 2-cycle pixel pipeline into the font ROM.
module text_overlay
    import text_overlay_pkg::*;
#(
    parameter int NUM_FIELDS = 3,
    parameter int DIGITS     = 6,
    parameter int VAL_W      = 20,
    parameter int SCALE_LOG2 = 0,
    parameter int ORIGIN_X   = 480,
    parameter int ORIGIN_Y   = 64,
    parameter int LINE_PITCH = 24,
    parameter int BLANK_LZ   = 1,
    localparam int FID_W     = (NUM_FIELDS > 1) ? $clog2(NUM_FIELDS) : 1
) (
    input  logic                        Clk,
    input  logic                        Reset,
    input  logic                        frame_start,
    input  logic [9:0]                  DrawX,
    input  logic [9:0]                  DrawY,
    input  logic [NUM_FIELDS*VAL_W-1:0] values,
    output logic                        is_letter,
    output logic [FID_W-1:0]            field_id,
    output logic                        busy
);

    localparam int BCD_W  = DIGITS * 4;
    localparam int CELL_W = CHAR_W << SCALE_LOG2;
    localparam int CELL_H = CHAR_H << SCALE_LOG2;
    localparam int PITCH  = LINE_PITCH << SCALE_LOG2;
    localparam logic [FID_W-1:0] LAST_F = FID_W'(NUM_FIELDS - 1);

    conv_state_t                  r_state;
    logic [FID_W-1:0]             r_fidx;
    logic [NUM_FIELDS*VAL_W-1:0]  r_shadow;
    logic                         r_start;
    logic                         r_busy;
    logic                         r_front;
    logic [BCD_W-1:0]             r_buf [2][NUM_FIELDS];

    logic [VAL_W-1:0]             w_conv_bin;
    logic                         w_conv_done;
    logic [BCD_W-1:0]             w_conv_bcd;
    logic                         w_conv_ovf;

    always_comb begin
        w_conv_bin = '0;
        for (int f = 0; f < NUM_FIELDS; f++) begin
            if (r_fidx == FID_W'(f)) w_conv_bin = r_shadow[f*VAL_W +: VAL_W];
        end
    end

    bin2bcd_seq #(.VAL_W(VAL_W), .DIGITS(DIGITS)) u_bin2bcd (
        .Clk      (Clk),
        .Reset    (Reset),
        .start    (r_start),
        .bin      (w_conv_bin),
        .done     (w_conv_done),
        .bcd      (w_conv_bcd),
        .overflow (w_conv_ovf)
    );

    // busy is held through the cycle after the swap so a new frame never races the commit.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state  <= IDLE;
            r_fidx   <= '0;
            r_shadow <= '0;
            r_start  <= 1'b0;
            r_busy   <= 1'b0;
            r_front  <= 1'b0;
            for (int b = 0; b < 2; b++) begin
                for (int f = 0; f < NUM_FIELDS; f++) r_buf[b][f] <= '0;
            end
        end else begin
            r_start <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (r_busy) begin
                        r_busy <= 1'b0;
                    end else if (frame_start) begin
                        r_shadow <= values;
                        r_fidx   <= '0;
                        r_start  <= 1'b1;
                        r_busy   <= 1'b1;
                        r_state  <= LOAD;
                    end
                end
                LOAD:  r_state <= SHIFT;
                SHIFT: if (w_conv_done) r_state <= STORE;
                STORE: begin
                    r_buf[~r_front][r_fidx] <= w_conv_ovf ? {DIGITS{4'h9}} : w_conv_bcd;
                    if (r_fidx == LAST_F) begin
                        r_state <= COMMIT;
                    end else begin
                        r_fidx  <= r_fidx + 1'b1;
                        r_start <= 1'b1;
                        r_state <= LOAD;
                    end
                end
                COMMIT: begin
                    r_front <= ~r_front;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    int               w_px, w_py, w_dx, w_dy, w_col;
    logic             w_xok, w_yok, w_hit, w_nz, w_blank;
    logic [FID_W-1:0] w_fsel;
    logic [BCD_W-1:0] w_word;
    bcd_digit_t       w_digit;
    logic [6:0]       w_code;
    logic [3:0]       w_row;
    logic [2:0]       w_bit;

    // Stage 1 decode: locate the cell, pick the digit from the front buffer, form the ROM address.
    always_comb begin
        w_px   = 32'(DrawX);
        w_py   = 32'(DrawY);
        w_dx   = w_px - ORIGIN_X;
        w_xok  = (w_dx >= 0) && (w_dx < DIGITS * CELL_W);
        w_yok  = 1'b0;
        w_fsel = '0;
        w_dy   = 0;
        for (int f = 0; f < NUM_FIELDS; f++) begin
            if (w_py >= ORIGIN_Y + f*PITCH && w_py < ORIGIN_Y + f*PITCH + CELL_H) begin
                w_yok  = 1'b1;
                w_fsel = FID_W'(f);
                w_dy   = w_py - (ORIGIN_Y + f*PITCH);
            end
        end
        w_hit = w_xok && w_yok;
        w_col = w_dx >>> ($clog2(CHAR_W) + SCALE_LOG2);

        w_word = '0;
        for (int f = 0; f < NUM_FIELDS; f++) begin
            if (w_fsel == FID_W'(f)) w_word = r_buf[r_front][f];
        end

        w_digit = '0;
        w_nz    = 1'b0;
        for (int k = 0; k < DIGITS; k++) begin
            if (k == DIGITS - 1 - w_col) w_digit = w_word[k*4 +: 4];
            if (k >= DIGITS - 1 - w_col && w_word[k*4 +: 4] != 4'd0) w_nz = 1'b1;
        end
        w_blank = (BLANK_LZ != 0) && (w_col != DIGITS - 1) && !w_nz;

        w_code = (!w_hit || w_blank) ? ASCII_SPACE[6:0] : 7'(ASCII_ZERO[6:0] + {3'd0, w_digit});
        w_row  = 4'(w_dy >>> SCALE_LOG2);
        w_bit  = 3'(w_dx >>> SCALE_LOG2);
    end

    logic [10:0]      r_addr1;
    logic             r_hit1, r_hit2;
    logic [2:0]       r_bit1, r_bit2;
    logic [FID_W-1:0] r_fid1, r_fid2;
    logic [7:0]       w_rom;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_addr1 <= '0;
            r_hit1  <= 1'b0;
            r_bit1  <= '0;
            r_fid1  <= '0;
            r_hit2  <= 1'b0;
            r_bit2  <= '0;
            r_fid2  <= '0;
        end else begin
            r_addr1 <= {w_code, w_row};
            r_hit1  <= w_hit;
            r_bit1  <= w_bit;
            r_fid1  <= w_hit ? w_fsel : '0;
            r_hit2  <= r_hit1;
            r_bit2  <= r_bit1;
            r_fid2  <= r_fid1;
        end
    end

    font_rom u_font (
        .Clk  (Clk),
        .addr (r_addr1),
        .data (w_rom)
    );

    assign is_letter = r_hit2 & w_rom[3'd7 - r_bit2];
    assign field_id  = r_fid2;
    assign busy      = r_busy;

endmodule

// File: tb/tb_text_overlay.sv
// Scoreboard bench for text_overlay: one instance at scale 1x and one at 2x share all inputs.
module tb_text_overlay;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        frameStart;
    logic [9:0]  drawX, drawY;
    logic [59:0] values;
    logic        isLetter0, isLetter1;
    logic [1:0]  fieldId0, fieldId1;
    logic        busy0, busy1;

    int nTests = 0;
    int nFail  = 0;
    int dispVals [3];

    typedef struct {
        int x;
        int y;
        int e0;
        int e1;
    } pix_t;
    pix_t sb [$];

    always #5 Clk = ~Clk;

    text_overlay #(.SCALE_LOG2(0)) dut0 (
        .Clk(Clk), .Reset(Reset), .frame_start(frameStart), .DrawX(drawX), .DrawY(drawY),
        .values(values), .is_letter(isLetter0), .field_id(fieldId0), .busy(busy0)
    );

    text_overlay #(.SCALE_LOG2(1)) dut1 (
        .Clk(Clk), .Reset(Reset), .frame_start(frameStart), .DrawX(drawX), .DrawY(drawY),
        .values(values), .is_letter(isLetter1), .field_id(fieldId1), .busy(busy1)
    );

    function automatic logic [127:0] glyph(input int code);
        case (code)
            'h30: return 128'h00007CC6C6CEDEF6E6C6C67C00000000;
            'h31: return 128'h00001838781818181818187E00000000;
            'h32: return 128'h00007CC6060C183060C0C6FE00000000;
            'h33: return 128'h00007CC606063C060606C67C00000000;
            'h34: return 128'h00000C1C3C6CCCFE0C0C0C1E00000000;
            'h35: return 128'h0000FEC0C0C0FC060606C67C00000000;
            'h36: return 128'h00003860C0C0FCC6C6C6C67C00000000;
            'h37: return 128'h0000FEC606060C183030303000000000;
            'h38: return 128'h00007CC6C6C67CC6C6C6C67C00000000;
            'h39: return 128'h00007CC6C6C67E0606060C7800000000;
            default: return 128'h0;
        endcase
    endfunction

    function automatic int fontBit(input int code, input int r, input int b);
        logic [127:0] g;
        logic [7:0]   row;
        g   = glyph(code);
        row = g[127 - 8*r -: 8];
        return row[7 - b] ? 1 : 0;
    endfunction

    // Character shown in column col (0 = most significant) for value v.
    function automatic int dispCode(input int v, input int col);
        int sat, pos, p;
        sat = (v > 999999) ? 999999 : v;
        pos = 5 - col;
        p   = 1;
        for (int i = 0; i < pos; i++) p = p * 10;
        if (pos > 0 && sat < p) return 'h20;
        return 'h30 + (sat / p) % 10;
    endfunction

    // Expected {field_id, is_letter} encoded as fid*2 + letter.
    function automatic int modelPixel(input int s, input int x, input int y);
        int cw, chh, pitch, base, col, r, b;
        cw    = 8 << s;
        chh   = 16 << s;
        pitch = 24 << s;
        if (x < 480 || x >= 480 + 6*cw) return 0;
        for (int f = 0; f < 3; f++) begin
            base = 64 + f*pitch;
            if (y >= base && y < base + chh) begin
                col = (x - 480) / cw;
                r   = (y - base) >> s;
                b   = ((x - 480) % cw) >> s;
                return f*2 + fontBit(dispCode(dispVals[f], col), r, b);
            end
        end
        return 0;
    endfunction

    task automatic popAndCompare();
        pix_t p;
        p = sb.pop_front();
        nTests++;
        if ({fieldId0, isLetter0} !== 3'(p.e0)) begin
            nFail++;
            $display("[TB] FAIL pixel_x1 (%0d,%0d) got fid/letter=%b want %b", p.x, p.y, {fieldId0, isLetter0}, 3'(p.e0));
        end
        nTests++;
        if ({fieldId1, isLetter1} !== 3'(p.e1)) begin
            nFail++;
            $display("[TB] FAIL pixel_x2 (%0d,%0d) got fid/letter=%b want %b", p.x, p.y, {fieldId1, isLetter1}, 3'(p.e1));
        end
    endtask

    task automatic scan(input int x0, input int x1, input int y0, input int y1);
        pix_t p;
        for (int y = y0; y <= y1; y++) begin
            for (int x = x0; x <= x1; x++) begin
                @(negedge Clk);
                if (sb.size() == 2) popAndCompare();
                drawX = 10'(x);
                drawY = 10'(y);
                p.x  = x;
                p.y  = y;
                p.e0 = modelPixel(0, x, y);
                p.e1 = modelPixel(1, x, y);
                sb.push_back(p);
            end
        end
        repeat (2) begin
            @(negedge Clk);
            popAndCompare();
        end
    endtask

    task automatic scanLines1x();
        for (int f = 0; f < 3; f++) scan(478, 529, 64 + 24*f - 1, 64 + 24*f + 16);
    endtask

    task automatic setValues(input int score, input int level, input int rows);
        values = {20'(rows), 20'(level), 20'(score)};
    endtask

    task automatic pulseFrame();
        @(negedge Clk);
        frameStart = 1'b1;
        @(negedge Clk);
        frameStart = 1'b0;
    endtask

    task automatic waitIdle(input string name);
        int c = 0;
        while ((busy0 || busy1) && c < 500) begin
            @(negedge Clk);
            c++;
        end
        nTests++;
        if (busy0 || busy1) begin
            nFail++;
            $display("[TB] FAIL %s_timeout busy=%b%b want 00", name, busy0, busy1);
        end
    endtask

    task automatic test_reset();
        Reset = 1'b1; frameStart = 1'b0; drawX = '0; drawY = '0;
        setValues(0, 0, 0);
        repeat (3) @(negedge Clk);
        nTests++;
        if (busy0 !== 1'b0 || busy1 !== 1'b0) begin
            nFail++; $display("[TB] FAIL reset_busy got %b%b want 00", busy0, busy1);
        end
        nTests++;
        if (isLetter0 !== 1'b0 || isLetter1 !== 1'b0) begin
            nFail++; $display("[TB] FAIL reset_letter got %b%b want 00", isLetter0, isLetter1);
        end
        nTests++;
        if (fieldId0 !== 2'd0 || fieldId1 !== 2'd0) begin
            nFail++; $display("[TB] FAIL reset_fid got %0d/%0d want 0", fieldId0, fieldId1);
        end
        Reset = 1'b0;
        dispVals = '{0, 0, 0};
        scanLines1x();
    endtask

    task automatic test_convert();
        int cnt = 0;
        setValues(123456, 7, 42);
        pulseFrame();
        while (busy0 && cnt < 200) begin
            cnt++;
            @(negedge Clk);
        end
        nTests++;
        if (cnt != 71) begin
            nFail++; $display("[TB] FAIL busy_length got %0d want 71", cnt);
        end
        nTests++;
        if (busy1 !== 1'b0) begin
            nFail++; $display("[TB] FAIL busy_x2_end got %b want 0", busy1);
        end
        dispVals = '{123456, 7, 42};
        scanLines1x();
    endtask

    task automatic test_saturation();
        setValues(1048575, 999999, 1000000);
        pulseFrame();
        waitIdle("saturation");
        dispVals = '{1048575, 999999, 1000000};
        scanLines1x();
    endtask

    task automatic test_back_to_back();
        int cnt = 0;
        setValues(654321, 80, 9);
        pulseFrame();
        while (busy0 && cnt < 200) begin
            cnt++;
            frameStart = (cnt == 10 || cnt == 70 || cnt == 71);
            if (cnt == 10) setValues(1, 22, 333);
            @(negedge Clk);
        end
        frameStart = 1'b0;
        nTests++;
        if (cnt != 71) begin
            nFail++; $display("[TB] FAIL b2b_busy_length got %0d want 71", cnt);
        end
        repeat (3) begin
            @(negedge Clk);
            nTests++;
            if (busy0 !== 1'b0 || busy1 !== 1'b0) begin
                nFail++; $display("[TB] FAIL b2b_no_restart busy=%b%b want 00", busy0, busy1);
            end
        end
        dispVals = '{654321, 80, 9};
        scanLines1x();
        pulseFrame();
        waitIdle("b2b_second");
        dispVals = '{1, 22, 333};
        scanLines1x();
    endtask

    task automatic test_scale_and_abort();
        scan(478, 578, 63, 96);
        scan(570, 577, 188, 192);
        setValues(777777, 5, 6);
        pulseFrame();
        repeat (11) @(negedge Clk);
        Reset = 1'b1;
        @(negedge Clk);
        Reset = 1'b0;
        nTests++;
        if (busy0 !== 1'b0 || busy1 !== 1'b0) begin
            nFail++; $display("[TB] FAIL abort_busy got %b%b want 00", busy0, busy1);
        end
        dispVals = '{0, 0, 0};
        scanLines1x();
        scan(478, 578, 158, 193);
    endtask

    initial begin
        test_reset();
        test_convert();
        test_saturation();
        test_back_to_back();
        test_scale_and_abort();
        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

    initial begin
        #5000000;
        $display("[TB] FAIL watchdog expired after %0d tests", nTests);
        $fatal(1, "[TB] watchdog");
    end

endmodule
